// File: rtl/qos_pkg.sv
// Shared definitions for the QoS ingress classifier: class field geometry
// and the classifier FSM state encoding.
package qos_pkg;

  localparam int CLS_W       = 2;
  localparam int NUM_CLS     = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int CLS_MSB     = DEF_DATA_W - 1;

  typedef logic [CLS_W-1:0] cls_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADED  = 2'd1,
    ST_BLOCKED = 2'd2
  } state_e;

endpackage : qos_pkg

// File: rtl/qos_stat_counter.sv
// Free-running statistics counter: synchronous clear, increment enable,
// wraps modulo 2^CNT_W.
module qos_stat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_en) count_d = count_q + CNT_W'(1);
  end

  // NOTE: sequential state is only ever updated with non-blocking assignments
  // so every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule : qos_stat_counter

// File: rtl/qos_classifier.sv
// Ingress classifier: holds one word, decodes its class from the two MSBs
// and pushes it one-hot into the matching class FIFO, stalling on full.
module qos_classifier
  import qos_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               ENABLE,
  input  logic [DATA_W-1:0]  DATA_IN,
  input  logic               VALID_IN,
  output logic               READY_OUT,
  input  logic [NUM_CLS-1:0] FULL,
  output logic [DATA_W-1:0]  DATA_OUT,
  output logic [NUM_CLS-1:0] PUSH,
  input  logic [CLS_W-1:0]   CNT_SEL,
  output logic [CNT_W-1:0]   CNT_OUT,
  output logic [CNT_W-1:0]   STALL_CNT
);

  state_e            state_q,     state_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  cls_t              hold_cls_q,  hold_cls_d;

  logic hold_valid;
  logic fire;
  logic ready;
  logic accept;

  logic [CNT_W-1:0] cls_cnt [NUM_CLS];

  // A word is held exactly when the FSM is in LOADED or BLOCKED; deriving it
  // from the state keeps the two from ever disagreeing.
  assign hold_valid = (state_q == ST_LOADED) || (state_q == ST_BLOCKED);

  always_comb begin
    fire   = hold_valid && !FULL[hold_cls_q];
    ready  = ENABLE && !RESET && (!hold_valid || fire);
    accept = VALID_IN && ready;
  end

  // NOTE: every variable driven here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_cls_d  = hold_cls_q;
    unique case (state_q)
      ST_IDLE:              state_d = accept ? ST_LOADED : ST_IDLE;
      ST_LOADED, ST_BLOCKED: begin
        if (fire) state_d = accept ? ST_LOADED : ST_IDLE;
        else      state_d = ST_BLOCKED;
      end
      default:              state_d = ST_IDLE;
    endcase
    if (accept) begin
      hold_data_d = DATA_IN;
      hold_cls_d  = DATA_IN[DATA_W-1 -: CLS_W];
    end
  end

  // NOTE: the hold data is cleared on reset as well, because DATA_OUT must
  // read zero after reset rather than a stale word.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      hold_data_q <= '0;
      hold_cls_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_cls_q  <= hold_cls_d;
    end
  end

  always_comb begin
    PUSH = '0;
    if (fire && !RESET) PUSH = NUM_CLS'(1) << hold_cls_q;
  end

  assign READY_OUT = ready;
  assign DATA_OUT  = hold_data_q;

  for (genvar i = 0; i < NUM_CLS; i++) begin : g_cls_cnt
    qos_stat_counter #(.CNT_W(CNT_W)) u_cls_cnt (
      .clk    (CLK),
      .rst    (RESET),
      .inc_en (fire && (hold_cls_q == cls_t'(i))),
      .count  (cls_cnt[i])
    );
  end

  qos_stat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk    (CLK),
    .rst    (RESET),
    .inc_en ((state_q == ST_BLOCKED) && !fire),
    .count  (STALL_CNT)
  );

  assign CNT_OUT = cls_cnt[CNT_SEL];

endmodule : qos_classifier

// File: tb/tb_qos_classifier.sv
// Self-checking bench for qos_classifier: a word-level reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_qos_classifier;

  logic        CLK = 1'b0;
  logic        RESET, ENABLE, VALID_IN;
  logic [7:0]  DATA_IN;
  logic        READY_OUT;
  logic [3:0]  FULL;
  logic [7:0]  DATA_OUT;
  logic [3:0]  PUSH;
  logic [1:0]  CNT_SEL;
  logic [15:0] CNT_OUT, STALL_CNT;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  qos_classifier #(.DATA_W(8), .CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .DATA_IN(DATA_IN),
    .VALID_IN(VALID_IN), .READY_OUT(READY_OUT), .FULL(FULL),
    .DATA_OUT(DATA_OUT), .PUSH(PUSH), .CNT_SEL(CNT_SEL),
    .CNT_OUT(CNT_OUT), .STALL_CNT(STALL_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one held word, how many times it has been offered,
  // per-class push totals and blocked-cycle total.
  bit          m_held = 1'b0;
  logic [7:0]  m_data = 8'h00;
  int          m_tries = 0;
  logic [15:0] m_cnt [4];
  logic [15:0] m_stall = 16'h0;
  bit          m_fire, m_ready;
  int          m_cls;

  always @(posedge CLK) begin
    if (RESET) begin
      m_held = 1'b0; m_data = 8'h00; m_tries = 0; m_stall = 16'h0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 16'h0;
    end else begin
      m_cls   = int'(m_data[7:6]);
      m_fire  = m_held && !FULL[m_cls];
      m_ready = ENABLE && (!m_held || m_fire);
      if (m_fire) m_cnt[m_cls] = m_cnt[m_cls] + 16'd1;
      else if (m_held && m_tries > 0) m_stall = m_stall + 16'd1;
      if (m_held && !m_fire) m_tries++;
      if (VALID_IN && m_ready) begin
        m_held = 1'b1; m_data = DATA_IN; m_tries = 0;
      end else if (m_fire) begin
        m_held = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      automatic int  c    = int'(m_data[7:6]);
      automatic bit  f    = m_held && !FULL[c] && !RESET;
      automatic logic [3:0] ep = f ? (4'b0001 << c) : 4'b0000;
      automatic bit  er   = ENABLE && !RESET && (!m_held || !FULL[c]);
      check("model_push",  32'(PUSH), 32'(ep));
      check("model_ready", 32'(READY_OUT), 32'(er));
      check("model_data",  32'(DATA_OUT), 32'(m_data));
      check("model_cnt",   32'(CNT_OUT), 32'(m_cnt[CNT_SEL]));
      check("model_stall", 32'(STALL_CNT), 32'(m_stall));
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // Directed checks sample mid-cycle, clear of both the edge and the model compare.
  task automatic probe();
    @(negedge CLK); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] words [4];

  initial begin
    RESET = 1'b1; ENABLE = 1'b1; VALID_IN = 1'b0; DATA_IN = 8'h00;
    FULL = 4'b0000; CNT_SEL = 2'd0;
    tick();
    cmp_en = 1'b1;
    probe();
    check("rst_ready", 32'(READY_OUT), 32'd0);
    check("rst_push",  32'(PUSH), 32'd0);
    tick();
    RESET = 1'b0;
    probe();
    check("rst_data",  32'(DATA_OUT), 32'h00);
    check("rst_stall", 32'(STALL_CNT), 32'd0);
    check("rst_cnt",   32'(CNT_OUT), 32'd0);
    check("idle_ready", 32'(READY_OUT), 32'd1);

    // Back-to-back stream, one word of each class.
    words[0] = 8'h05; words[1] = 8'h4A; words[2] = 8'h8F; words[3] = 8'hC3;
    @(posedge CLK); #1;
    for (int i = 0; i < 4; i++) begin
      DATA_IN = words[i]; VALID_IN = 1'b1;
      tick();
      probe();
      check("stream_push",  32'(PUSH), 32'(4'b0001 << i));
      check("stream_data",  32'(DATA_OUT), 32'(words[i]));
      check("stream_ready", 32'(READY_OUT), 32'd1);
    end
    VALID_IN = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      CNT_SEL = 2'(i);
      #1 check("stream_cnt", 32'(CNT_OUT), 32'd1);
    end

    // Target full: word 0x80 stalls in BLOCKED.
    FULL = 4'b0100; DATA_IN = 8'h80; VALID_IN = 1'b1;
    tick();
    VALID_IN = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    probe();
    check("blk_ready", 32'(READY_OUT), 32'd0);
    check("blk_push",  32'(PUSH), 32'd0);
    check("blk_stall", 32'(STALL_CNT), 32'd5);
    FULL = 4'b0000;
    #1 check("blk_release_push", 32'(PUSH), 32'b0100);
    tick();
    probe();
    check("blk_after_push", 32'(PUSH), 32'd0);
    CNT_SEL = 2'd2;
    #1 check("blk_cnt2", 32'(CNT_OUT), 32'd2);

    // A full flag of another class never stalls.
    FULL = 4'b0001; DATA_IN = 8'h40; VALID_IN = 1'b1;
    tick();
    VALID_IN = 1'b0;
    probe();
    check("other_full_push", 32'(PUSH), 32'b0010);
    tick();
    check("other_full_stall", 32'(STALL_CNT), 32'd5);

    // Reset while holding a blocked word: the word is discarded.
    FULL = 4'b1000; DATA_IN = 8'hC0; VALID_IN = 1'b1;
    tick();
    VALID_IN = 1'b0;
    tick(); tick();
    probe();
    check("hold_c0_push", 32'(PUSH), 32'd0);
    @(posedge CLK); #1 RESET = 1'b1;
    probe();
    check("mid_rst_push",  32'(PUSH), 32'd0);
    check("mid_rst_ready", 32'(READY_OUT), 32'd0);
    tick();
    RESET = 1'b0; FULL = 4'b0000;
    probe();
    check("post_rst_push",  32'(PUSH), 32'd0);
    check("post_rst_ready", 32'(READY_OUT), 32'd1);
    check("post_rst_stall", 32'(STALL_CNT), 32'd0);
    CNT_SEL = 2'd3;
    #1 check("post_rst_cnt3", 32'(CNT_OUT), 32'd0);

    // ENABLE drop while holding a blocked word.
    @(posedge CLK); #1;
    FULL = 4'b0010; DATA_IN = 8'h41; VALID_IN = 1'b1;
    tick();
    ENABLE = 1'b0; VALID_IN = 1'b0;
    probe();
    check("dis_ready", 32'(READY_OUT), 32'd0);
    tick(); tick();
    FULL = 4'b0000;
    #1 check("dis_push", 32'(PUSH), 32'b0010);
    check("dis_ready_fire", 32'(READY_OUT), 32'd0);
    tick();
    DATA_IN = 8'h11; VALID_IN = 1'b1;
    tick();
    probe();
    check("dis_no_capture", 32'(PUSH), 32'd0);
    check("dis_ready_idle", 32'(READY_OUT), 32'd0);
    VALID_IN = 1'b0; ENABLE = 1'b1;
    #1 check("en_ready", 32'(READY_OUT), 32'd1);
    CNT_SEL = 2'd1;
    #1 check("dis_cnt1", 32'(CNT_OUT), 32'd1);

    // Counter wrap: 2^16 class-0 pushes after a fresh reset.
    @(posedge CLK); #1 RESET = 1'b1;
    tick();
    RESET = 1'b0; CNT_SEL = 2'd0; DATA_IN = 8'h00; VALID_IN = 1'b1;
    for (int i = 0; i < 65536; i++) tick();
    VALID_IN = 1'b0;
    tick();
    probe();
    check("wrap_zero", 32'(CNT_OUT), 32'h0000);
    VALID_IN = 1'b1;
    tick();
    VALID_IN = 1'b0;
    tick();
    probe();
    check("wrap_one", 32'(CNT_OUT), 32'h0001);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_qos_classifier
